// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the seven-segment scanner.
package seg_scan_pkg;

  // Width of one digit's segment pattern.
  localparam int SEG_W = 7;

  // Number of digit inputs the scanner exposes (d1..d6).
  localparam int SCAN_DIGITS = 6;

  // Logical "no segment lit" pattern, before pin polarity is applied.
  localparam logic [SEG_W-1:0] SEG_OFF = '0;

  // Index of the digit currently being scanned.
  typedef logic [$clog2(SCAN_DIGITS)-1:0] digit_idx_t;

  // SCAN lights a digit; BLANK is the optional dead time between digits.
  typedef enum logic {
    SCAN  = 1'b0,
    BLANK = 1'b1
  } state_t;

  // Map a logical pattern (1 = lit) onto the pin level the board needs.
  function automatic logic [SEG_W-1:0] seg_drive(input logic [SEG_W-1:0] lit,
                                                 input logic active_low);
    return active_low ? ~lit : lit;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_divider.sv
// refresh_divider: modulo-N counter with enable. tick is high for the single
// enabled cycle in which the count sits at N-1; the count then returns to 0.
module refresh_divider #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  // A modulus of 1 still needs a one-bit counter to keep the widths legal.
  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count_reg;

  assign tick = en && (count_reg == LAST);

  // Count while enabled, wrapping at the terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= tick ? '0 : count_reg + W'(1);
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexes six 7-segment patterns onto one shared
// segment bus with per-digit anode enables. All six patterns are snapshotted
// once per frame so a digit never changes partway through a frame.
// Optional build macro SEVEN_SEG_SCANNER_GHOST_BLANK_EN inserts BLANK_CYCLES of
// all-anodes-off dead time after every digit to suppress ghosting.
module seven_seg_scanner
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS     = SCAN_DIGITS,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [SEG_W-1:0]      d1,
  input  logic [SEG_W-1:0]      d2,
  input  logic [SEG_W-1:0]      d3,
  input  logic [SEG_W-1:0]      d4,
  input  logic [SEG_W-1:0]      d5,
  input  logic [SEG_W-1:0]      d6,
  output logic [SEG_W-1:0]      seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_tick
);

  // Reject configurations the counters and ports cannot represent.
  if (REFRESH_DIV < 2 || BLANK_CYCLES < 1 || NUM_DIGITS < 1 || NUM_DIGITS > SCAN_DIGITS)
  begin : g_bad_params
    $error("seven_seg_scanner: unsupported parameter combination");
  end

  localparam logic                  SEG_LOW  = (SEG_ACTIVE_LOW != 0);
  localparam logic                  AN_LOW   = (AN_ACTIVE_LOW != 0);
  localparam logic [SEG_W-1:0]      SEG_PINS_OFF = seg_drive(SEG_OFF, SEG_LOW);
  localparam logic [NUM_DIGITS-1:0] AN_PINS_OFF  = AN_LOW ? '1 : '0;
  localparam digit_idx_t            LAST_IDX = digit_idx_t'(NUM_DIGITS - 1);

  logic [SEG_W-1:0]      din [SCAN_DIGITS];
  logic [SEG_W-1:0]      snap_reg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] an_sel;
  digit_idx_t            idx_reg;
  logic                  load_pending_reg;
  state_t                state_reg, state_next;
  logic                  scan_go, div_en, div_tick, advance, wrap, load, lit;

  assign din[0] = d1;
  assign din[1] = d2;
  assign din[2] = d3;
  assign din[3] = d4;
  assign din[4] = d5;
  assign din[5] = d6;

  // Nothing scans until the first snapshot has been taken.
  assign scan_go = en && !load_pending_reg;
  assign wrap    = advance && (idx_reg == LAST_IDX);
  assign load    = (en && load_pending_reg) || wrap;
  assign lit     = scan_go && (state_reg == SCAN);

  // One-hot decode of the current digit index.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an_sel
    assign an_sel[gi] = (idx_reg == digit_idx_t'(gi));
  end

  refresh_divider #(.N(REFRESH_DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (div_en),
    .tick  (div_tick)
  );

`ifdef SEVEN_SEG_SCANNER_GHOST_BLANK_EN
  logic blank_en, blank_tick;

  refresh_divider #(.N(BLANK_CYCLES)) u_blank (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (blank_en),
    .tick  (blank_tick)
  );
`endif

  // State register for the SCAN/BLANK sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= SCAN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state, counter enables and the digit-advance strobe.
  always_comb begin
    state_next = state_reg;
    div_en     = 1'b0;
    advance    = 1'b0;
`ifdef SEVEN_SEG_SCANNER_GHOST_BLANK_EN
    blank_en   = 1'b0;
`endif
    case (state_reg)
`ifdef SEVEN_SEG_SCANNER_GHOST_BLANK_EN
      BLANK: begin
        blank_en = en;
        if (blank_tick) begin
          advance    = 1'b1;
          state_next = SCAN;
        end
      end
`endif
      default: begin
        div_en = scan_go;
        if (div_tick) begin
`ifdef SEVEN_SEG_SCANNER_GHOST_BLANK_EN
          state_next = BLANK;
`else
          advance    = 1'b1;
`endif
        end
      end
    endcase
  end

  // Digit index, first-load bookkeeping and the per-frame snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_pending_reg <= 1'b1;
      idx_reg          <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) snap_reg[i] <= '0;
    end else begin
      if (en && load_pending_reg) load_pending_reg <= 1'b0;
      if (advance) idx_reg <= wrap ? '0 : idx_reg + digit_idx_t'(1);
      if (load) begin
        for (int i = 0; i < NUM_DIGITS; i++) snap_reg[i] <= din[i];
      end
    end
  end

  // Registered pin drivers: current digit while scanning, otherwise all off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_PINS_OFF;
      an         <= AN_PINS_OFF;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= load;
      if (lit) begin
        seg <= seg_drive(snap_reg[idx_reg], SEG_LOW);
        an  <= AN_LOW ? ~an_sel : an_sel;
      end else begin
        seg <= SEG_PINS_OFF;
        an  <= AN_PINS_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with REFRESH_DIV=4, BLANK_CYCLES=2.
// Honours SEVEN_SEG_SCANNER_GHOST_BLANK_EN for the blank-gap expectations.
module tb_seven_seg_scanner;

  localparam int R = 4;
  localparam int B = 2;
`ifdef SEVEN_SEG_SCANNER_GHOST_BLANK_EN
  localparam int FRAME_CYC = 6 * (R + B);
`else
  localparam int FRAME_CYC = 6 * R;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [6:0] din [6];
  logic [6:0] seg;
  logic [5:0] an;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;

  logic [6:0] cur_snap [6];
  int cyc = 0;
  int frames = 0;
  int last_ft_cyc = 0;
  int period = 0;
  int cur_digit = -1;
  int run_cnt = 0;

  seven_seg_scanner #(
    .NUM_DIGITS(6), .REFRESH_DIV(R), .BLANK_CYCLES(B),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .d1(din[0]), .d2(din[1]), .d3(din[2]), .d4(din[3]), .d5(din[4]), .d6(din[5]),
    .seg(seg), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Invariants watched on every falling edge: at most one anode active, and
  // each digit stays lit for exactly R active cycles (pauses excluded).
  always @(negedge clk) begin
    logic [5:0] act;
    int n, d;
    if (rst_n !== 1'b1) begin
      cur_digit = -1;
      run_cnt   = 0;
    end else begin
      act = ~an;
      n = $countones(act);
      chk("anode_count_le1", 32'(n <= 1), 32'd1);
      if (n == 1) begin
        d = 0;
        for (int i = 0; i < 6; i++) if (act[i]) d = i;
        if (d != cur_digit) begin
          if (cur_digit >= 0) chk("digit_active_len", run_cnt, R);
          cur_digit = d;
          run_cnt   = 1;
        end else begin
          run_cnt++;
        end
      end
      if (frame_tick === 1'b1) begin
        frames++;
        period      = cyc - last_ft_cyc;
        last_ft_cyc = cyc;
      end
    end
  end

  // n lit cycles of digit k; frame_tick expected on the last one if ft_last.
  task automatic lit(input int k, input int n, input bit ft_last);
    logic [5:0] an_exp;
    logic [6:0] seg_exp;
    bit ft_exp;
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      an_exp  = ~(6'b000001 << k);
      seg_exp = ~cur_snap[k];
      ft_exp  = ft_last && (j == n - 1);
      chk($sformatf("an_d%0d", k), an, an_exp);
      chk($sformatf("seg_d%0d", k), seg, seg_exp);
      chk($sformatf("ft_d%0d", k), frame_tick, ft_exp);
      if (ft_exp) for (int i = 0; i < 6; i++) cur_snap[i] = din[i];
    end
  endtask

  // n cycles of all-off outputs; frame_tick expected on the last one if ft_last.
  task automatic dark(input string tag, input int n, input bit ft_last);
    bit ft_exp;
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      ft_exp = ft_last && (j == n - 1);
      chk({tag, "_an"}, an, 6'h3F);
      chk({tag, "_seg"}, seg, 7'h7F);
      chk({tag, "_ft"}, frame_tick, ft_exp);
      if (ft_exp) for (int i = 0; i < 6; i++) cur_snap[i] = din[i];
    end
  endtask

  // Trailing part of a digit slot after its lit cycles.
  task automatic slot_tail(input bit last);
`ifdef SEVEN_SEG_SCANNER_GHOST_BLANK_EN
    dark("blank", B, last);
`else
    if (last) begin end
`endif
  endtask

  task automatic digit(input int k);
    bit last;
    last = (k == 5);
`ifdef SEVEN_SEG_SCANNER_GHOST_BLANK_EN
    lit(k, R, 1'b0);
`else
    lit(k, R, last);
`endif
    slot_tail(last);
  endtask

  initial begin
    int start_frames;
    int budget;
    rst_n = 1'b0;
    en    = 1'b1;
    din[0] = 7'h01; din[1] = 7'h02; din[2] = 7'h04;
    din[3] = 7'h08; din[4] = 7'h10; din[5] = 7'h20;
    for (int i = 0; i < 6; i++) cur_snap[i] = 7'h00;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_an", an, 6'h3F);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_ft", frame_tick, 1'b0);

    // Release: edge 1 loads the snapshot, digit 0 follows from edge 2.
    @(negedge clk) rst_n = 1'b1;
    dark("load", 1, 1'b1);

    // Frame 1: walking-one patterns, one digit after another.
    for (int k = 0; k < 6; k++) digit(k);

    // Frame 2: inputs change while digit 3 is lit; this frame must not see it.
    for (int k = 0; k < 3; k++) digit(k);
    lit(3, 2, 1'b0);
    din[0] = 7'h7F;
    din[5] = 7'h55;
    lit(3, R - 2, 1'b0);
    slot_tail(1'b0);
    digit(4);
    digit(5);
    #5;
    chk("frame_period", period, FRAME_CYC);

    // Frame 3: new snapshot visible; pause en at divider=2 of digit 4.
    for (int k = 0; k < 4; k++) digit(k);
    lit(4, 2, 1'b0);
    en = 1'b0;
    dark("pause", 10, 1'b0);
    en = 1'b1;
    lit(4, 2, 1'b0);
    slot_tail(1'b0);
    digit(5);

    // Frame 4: asynchronous reset in the middle of digit 5.
    for (int k = 0; k < 5; k++) digit(k);
    lit(5, 2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_an", an, 6'h3F);
    chk("async_rst_seg", seg, 7'h7F);
    chk("async_rst_ft", frame_tick, 1'b0);
    din[0] = 7'h11; din[1] = 7'h22; din[2] = 7'h33;
    din[3] = 7'h44; din[4] = 7'h55; din[5] = 7'h66;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dark("reload", 1, 1'b1);
    for (int k = 0; k < 6; k++) digit(k);

    // Random en toggling over 1000 frames; the monitor checks invariants.
    start_frames = frames;
    budget = 0;
    while ((frames - start_frames) < 1000 && budget < 80000) begin
      @(negedge clk);
      en = ($urandom_range(0, 3) != 0);
      budget++;
    end
    chk("random_frames_done", 32'((frames - start_frames) >= 1000), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
